// File: rtl/axi4_wr_arbiter_if.sv
// Bundle of the requester-side (s_*) and shared master-side (m_*) AXI4 write channels.
// "master" is the arbiter's view; "slave" is the surrounding requesters + downstream port.
interface axi4_wr_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 64,
    parameter int IDWIDTH   = 4
);
    localparam int PW   = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int MIDW = IDWIDTH + PW;

    logic [NUM_PORTS-1:0][IDWIDTH-1:0]  s_awid;
    logic [NUM_PORTS-1:0][AWIDTH-1:0]   s_awaddr;
    logic [NUM_PORTS-1:0][7:0]          s_awlen;
    logic [NUM_PORTS-1:0][2:0]          s_awsize;
    logic [NUM_PORTS-1:0][1:0]          s_awburst;
    logic [NUM_PORTS-1:0]               s_awvalid;
    logic [NUM_PORTS-1:0]               s_awready;
    logic [NUM_PORTS-1:0][DWIDTH-1:0]   s_wdata;
    logic [NUM_PORTS-1:0][DWIDTH/8-1:0] s_wstrb;
    logic [NUM_PORTS-1:0]               s_wlast;
    logic [NUM_PORTS-1:0]               s_wvalid;
    logic [NUM_PORTS-1:0]               s_wready;
    logic [NUM_PORTS-1:0][IDWIDTH-1:0]  s_bid;
    logic [NUM_PORTS-1:0][1:0]          s_bresp;
    logic [NUM_PORTS-1:0]               s_bvalid;
    logic [NUM_PORTS-1:0]               s_bready;

    logic [MIDW-1:0]     m_awid;
    logic [AWIDTH-1:0]   m_awaddr;
    logic [7:0]          m_awlen;
    logic [2:0]          m_awsize;
    logic [1:0]          m_awburst;
    logic                m_awvalid;
    logic                m_awready;
    logic [DWIDTH-1:0]   m_wdata;
    logic [DWIDTH/8-1:0] m_wstrb;
    logic                m_wlast;
    logic                m_wvalid;
    logic                m_wready;
    logic [MIDW-1:0]     m_bid;
    logic [1:0]          m_bresp;
    logic                m_bvalid;
    logic                m_bready;

    modport master (
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready,
        output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bid, m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready,
        input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bid, m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// Round-robin N:1 AXI4 write arbiter; master ID = {port, requester ID}, B routed back by that tag.
// Define AXI4_WR_ARB_LEN_CHECK_EN to build the sticky burst-length checker driving len_err.
module axi4_wr_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int AWIDTH          = 32,
    parameter int DWIDTH          = 64,
    parameter int IDWIDTH         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                clk,
    input  logic                reset,
    axi4_wr_arbiter_if.master   bus,
    output logic                len_err
);
    localparam int PW   = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int MIDW = IDWIDTH + PW;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] gnt, rr_ptr, sel, cand;
    logic [CW-1:0] out_cnt;
    logic          found, grant;
    logic          aw_hs, w_hs, b_hs;
    logic [PW-1:0] bidx;
    logic          bidx_ok;

    // first requester with awvalid at or above rr_ptr, wrapping
    always_comb begin
        sel   = gnt;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!found && bus.s_awvalid[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign grant = (state == ST_IDLE) && found && (out_cnt < CW'(MAX_OUTSTANDING));
    assign aw_hs = bus.m_awvalid && bus.m_awready;
    assign w_hs  = bus.m_wvalid && bus.m_wready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant)                state_nxt = ST_ADDR;
            ST_ADDR: if (aw_hs)                state_nxt = ST_DATA;
            ST_DATA: if (w_hs && bus.m_wlast)  state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.m_awid    = {gnt, bus.s_awid[gnt]};
        bus.m_awaddr  = bus.s_awaddr[gnt];
        bus.m_awlen   = bus.s_awlen[gnt];
        bus.m_awsize  = bus.s_awsize[gnt];
        bus.m_awburst = bus.s_awburst[gnt];
        bus.m_awvalid = 1'b0;
        bus.s_awready = '0;
        bus.m_wdata   = bus.s_wdata[gnt];
        bus.m_wstrb   = bus.s_wstrb[gnt];
        bus.m_wlast   = bus.s_wlast[gnt];
        bus.m_wvalid  = 1'b0;
        bus.s_wready  = '0;
        if (state == ST_ADDR) begin
            bus.m_awvalid      = bus.s_awvalid[gnt];
            bus.s_awready[gnt] = bus.m_awready;
        end
        // early W from any requester stalls here until its own data phase
        if (state == ST_DATA) begin
            bus.m_wvalid      = bus.s_wvalid[gnt];
            bus.s_wready[gnt] = bus.m_wready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt    <= '0;
            rr_ptr <= '0;
        end else if (grant) begin
            gnt    <= sel;
            rr_ptr <= (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + PW'(1);
        end
    end

    // B path: purely combinational demux on the port tag in the top ID bits
    assign bidx    = bus.m_bid[MIDW-1 -: PW];
    assign bidx_ok = int'(bidx) < NUM_PORTS;

    always_comb begin
        bus.s_bvalid = '0;
        bus.s_bid    = '0;
        bus.s_bresp  = '0;
        bus.m_bready = 1'b1;
        if (bidx_ok) begin
            bus.s_bvalid[bidx] = bus.m_bvalid;
            bus.s_bid[bidx]    = bus.m_bid[IDWIDTH-1:0];
            bus.s_bresp[bidx]  = bus.m_bresp;
            bus.m_bready       = bus.s_bready[bidx];
        end
    end

    // stray responses (bad tag, nothing outstanding) never move the counter
    assign b_hs = bus.m_bvalid && bus.m_bready && bidx_ok && (out_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset)               out_cnt <= '0;
        else if (aw_hs && !b_hs) out_cnt <= out_cnt + CW'(1);
        else if (b_hs && !aw_hs) out_cnt <= out_cnt - CW'(1);
    end

`ifdef AXI4_WR_ARB_LEN_CHECK_EN
    logic [7:0] beat_cnt, cur_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            cur_len  <= '0;
            len_err  <= 1'b0;
        end else begin
            if (aw_hs) begin
                beat_cnt <= '0;
                cur_len  <= bus.m_awlen;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (w_hs && ((bus.m_wlast && beat_cnt != cur_len) ||
                         (!bus.m_wlast && beat_cnt == cur_len)))
                len_err <= 1'b1;
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter: 3 ports, MAX_OUTSTANDING=2, hand-computed expectations.
module tb_axi4_wr_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int MO = 2;

`ifdef AXI4_WR_ARB_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic clk;
    logic reset;
    logic len_err;
    int   n_tests = 0;
    int   n_fail  = 0;

    axi4_wr_arbiter_if #(.NUM_PORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .IDWIDTH(IW)) bus ();

    axi4_wr_arbiter #(
        .NUM_PORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .IDWIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .len_err (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_inputs();
        bus.s_awid    = '0;
        bus.s_awaddr  = '0;
        bus.s_awlen   = '0;
        bus.s_awsize  = '0;
        bus.s_awburst = '0;
        bus.s_awvalid = '0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '1;
        bus.s_wlast   = '0;
        bus.s_wvalid  = '0;
        bus.s_bready  = '1;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.m_bid     = '0;
        bus.m_bresp   = '0;
        bus.m_bvalid  = 1'b0;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] ep;
        reset = 1'b1;
        do_reset();

        // reset state
        chk("rst_awvalid", bus.m_awvalid, 0);
        chk("rst_wvalid",  bus.m_wvalid, 0);
        chk("rst_awready", bus.s_awready, 0);
        chk("rst_wready",  bus.s_wready, 0);
        chk("rst_out_cnt", dut.out_cnt, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_bready",  bus.m_bready, 1);
        chk("rst_bvalid",  bus.s_bvalid, 0);

        // single requester, len=3, id=5
        bus.s_awid[0]    = 4'd5;
        bus.s_awaddr[0]  = 32'h0000_1000;
        bus.s_awlen[0]   = 8'd3;
        bus.s_awsize[0]  = 3'd3;
        bus.s_awburst[0] = 2'd1;
        bus.s_awvalid    = 3'b001;
        #1 chk("t1_idle_awvalid", bus.m_awvalid, 0);
        tick();
        chk("t1_awvalid", bus.m_awvalid, 1);
        chk("t1_awid",    bus.m_awid, 6'h05);
        chk("t1_awaddr",  bus.m_awaddr, 32'h0000_1000);
        chk("t1_awlen",   bus.m_awlen, 8'd3);
        chk("t1_awready", bus.s_awready, 3'b001);
        tick();
        bus.s_awvalid = '0;
        chk("t1_out_cnt1", dut.out_cnt, 1);
        for (int b = 0; b < 4; b++) begin
            bus.s_wvalid   = 3'b001;
            bus.s_wdata[0] = 64'h1111_0000_0000_0000 + 64'(b);
            bus.s_wlast    = (b == 3) ? 3'b001 : 3'b000;
            #1;
            chk("t1_wready", bus.s_wready, 3'b001);
            chk("t1_wdata",  bus.m_wdata, 64'h1111_0000_0000_0000 + 64'(b));
            chk("t1_wlast",  bus.m_wlast, (b == 3) ? 1 : 0);
            tick();
        end
        bus.s_wvalid = '0;
        bus.s_wlast  = '0;
        #1;
        chk("t1_wvalid_done", bus.m_wvalid, 0);
        chk("t1_len_err", len_err, 0);
        bus.m_bid    = 6'h05;
        bus.m_bresp  = 2'b01;
        bus.m_bvalid = 1'b1;
        #1;
        chk("t1_bvalid", bus.s_bvalid, 3'b001);
        chk("t1_bid",    bus.s_bid[0], 4'd5);
        chk("t1_bresp",  bus.s_bresp[0], 2'b01);
        chk("t1_bready", bus.m_bready, 1);
        tick();
        bus.m_bvalid = 1'b0;
        chk("t1_out_cnt0", dut.out_cnt, 0);

        // round robin: ports 0 and 1 both continuously requesting
        do_reset();
        bus.s_awid[0]  = 4'd1;
        bus.s_awid[1]  = 4'd2;
        bus.s_wdata[0] = 64'hA0;
        bus.s_wdata[1] = 64'hB1;
        bus.s_awvalid  = 3'b011;
        bus.s_wvalid   = 3'b011;
        bus.s_wlast    = 3'b011;
        for (int i = 0; i < 4; i++) begin
            ep = 2'(i % 2);
            tick();
            chk("rr_awid",       bus.m_awid, (ep == 2'd0) ? 6'h01 : 6'h12);
            chk("rr_awready",    bus.s_awready, (ep == 2'd0) ? 3'b001 : 3'b010);
            chk("rr_wrdy_addr",  bus.s_wready, 0);
            tick();
            chk("rr_wready",     bus.s_wready, (ep == 2'd0) ? 3'b001 : 3'b010);
            chk("rr_wdata",      bus.m_wdata, (ep == 2'd0) ? 64'hA0 : 64'hB1);
            bus.m_bid    = (ep == 2'd0) ? 6'h01 : 6'h12;
            bus.m_bvalid = 1'b1;
            #1 chk("rr_bvalid",  bus.s_bvalid, (ep == 2'd0) ? 3'b001 : 3'b010);
            tick();
            bus.m_bvalid = 1'b0;
        end
        bus.s_awvalid = '0;
        bus.s_wvalid  = '0;
        #1 chk("rr_out_cnt", dut.out_cnt, 0);

        // outstanding limit (2), then simultaneous AW + B
        do_reset();
        bus.s_awid[0] = 4'd9;
        bus.s_awvalid = 3'b001;
        bus.s_wvalid  = 3'b001;
        bus.s_wlast   = 3'b001;
        repeat (6) tick();
        chk("ol_out_cnt2", dut.out_cnt, 2);
        for (int i = 0; i < 3; i++) begin
            chk("ol_blocked", bus.m_awvalid, 0);
            tick();
        end
        bus.m_bid    = 6'h09;
        bus.m_bvalid = 1'b1;
        tick();
        bus.m_bvalid = 1'b0;
        chk("ol_out_cnt1", dut.out_cnt, 1);
        chk("ol_still_idle", bus.m_awvalid, 0);
        tick();
        chk("ol_issue3", bus.m_awvalid, 1);
        bus.m_bvalid = 1'b1;
        tick();
        bus.m_bvalid = 1'b0;
        chk("ol_aw_b_same", dut.out_cnt, 1);
        tick();
        bus.s_awvalid = '0;
        bus.s_wvalid  = '0;
        bus.m_bvalid  = 1'b1;
        tick();
        bus.m_bvalid = 1'b0;
        chk("ol_out_cnt0", dut.out_cnt, 0);
        // response tagged with a nonexistent port is swallowed
        bus.s_bready = '0;
        bus.m_bid    = 6'h31;
        bus.m_bvalid = 1'b1;
        #1;
        chk("drop_bready", bus.m_bready, 1);
        chk("drop_bvalid", bus.s_bvalid, 0);
        bus.m_bvalid = 1'b0;

        // early W on port 1
        do_reset();
        bus.s_wvalid   = 3'b010;
        bus.s_wdata[1] = 64'hD0;
        for (int i = 0; i < 5; i++) begin
            chk("ew_wait", bus.s_wready, 0);
            tick();
        end
        bus.s_awid[1] = 4'd7;
        bus.s_awlen[1] = 8'd1;
        bus.s_awvalid = 3'b010;
        tick();
        chk("ew_addr_wrdy", bus.s_wready, 0);
        chk("ew_awid", bus.m_awid, 6'h17);
        tick();
        bus.s_awvalid = '0;
        #1;
        chk("ew_wready", bus.s_wready, 3'b010);
        chk("ew_wdata0", bus.m_wdata, 64'hD0);
        chk("ew_wlast0", bus.m_wlast, 0);
        tick();
        bus.s_wdata[1] = 64'hD1;
        bus.s_wlast    = 3'b010;
        #1;
        chk("ew_wdata1", bus.m_wdata, 64'hD1);
        chk("ew_wlast1", bus.m_wlast, 1);
        tick();
        bus.s_wvalid = '0;
        #1 chk("ew_done", bus.m_wvalid, 0);

        // length check: awlen=3, wlast on third beat
        do_reset();
        bus.s_awlen[0] = 8'd3;
        bus.s_awvalid  = 3'b001;
        tick();
        tick();
        bus.s_awvalid = '0;
        for (int b = 0; b < 3; b++) begin
            bus.s_wvalid = 3'b001;
            bus.s_wlast  = (b == 2) ? 3'b001 : 3'b000;
            tick();
        end
        bus.s_wvalid = '0;
        bus.s_wlast  = '0;
        chk("lc_len_err", len_err, LEN_CHK);
        tick();
        tick();
        chk("lc_sticky", len_err, LEN_CHK);
        do_reset();
        chk("lc_cleared", len_err, 0);

        // reset during data beat 2 abandons burst, rr restarts at port 0
        bus.s_awlen[0] = 8'd3;
        bus.s_awvalid  = 3'b001;
        tick();
        tick();
        bus.s_awvalid = '0;
        bus.s_wvalid  = 3'b001;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rm_awvalid", bus.m_awvalid, 0);
        chk("rm_wvalid",  bus.m_wvalid, 0);
        chk("rm_out_cnt", dut.out_cnt, 0);
        chk("rm_wready",  bus.s_wready, 0);
        reset         = 1'b0;
        bus.s_wvalid  = '0;
        bus.s_awid[0] = 4'd3;
        bus.s_awid[1] = 4'd4;
        bus.s_awvalid = 3'b011;
        tick();
        chk("rm_rr_port0", bus.m_awid, 6'h03);
        bus.s_awvalid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_wr_arbiter.md
# axi4_wr_arbiter

- Shares one AXI4 write master port (AW/W/B) between NUM_PORTS requesters using round-robin arbitration.
- Tags each granted burst's ID with the requester index and routes B responses back by that tag.
- Sits between DMA/CHDR write engines and the DRAM/interconnect write port in the sim and FPGA fabric.

## Interface
Parameters:
- NUM_PORTS, 2: requester count (2..8).
- AWIDTH, 32: address width.
- DWIDTH, 64: data width; strobe width DWIDTH/8.
- IDWIDTH, 4: requester ID width. Master ID width MIDW = IDWIDTH + PW, where PW = max(1, $clog2(NUM_PORTS)).
- MAX_OUTSTANDING, 8: maximum bursts issued on AW and not yet answered on B.

Ports (all `s_*` signals are packed, port i at slice i):
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- s_awid / s_awaddr / s_awlen / s_awsize / s_awburst  in  NUM_PORTS×(IDWIDTH/AWIDTH/8/3/2)  requester AW fields
- s_awvalid  in  NUM_PORTS  AW valid
- s_awready  out  NUM_PORTS  AW ready
- s_wdata / s_wstrb / s_wlast / s_wvalid  in  NUM_PORTS×(DWIDTH/DWIDTH/8/1/1)  requester W
- s_wready  out  NUM_PORTS  W ready
- s_bid  out  NUM_PORTS×IDWIDTH  B ID
- s_bresp  out  NUM_PORTS×2  B response
- s_bvalid  out  NUM_PORTS  B valid
- s_bready  in  NUM_PORTS  B ready
- m_awid  out  MIDW  `{port index, s_awid}`
- m_awaddr / m_awlen / m_awsize / m_awburst / m_awvalid  out  AWIDTH/8/3/2/1  master AW
- m_awready  in  1  master AW ready
- m_wdata / m_wstrb / m_wlast / m_wvalid  out  DWIDTH/DWIDTH/8/1/1  master W
- m_wready  in  1  master W ready
- m_bid  in  MIDW  master B ID
- m_bresp  in  2  master B response
- m_bvalid  in  1  master B valid
- m_bready  out  1  master B ready
- len_err  out  1  sticky burst-length error; exists only with the macro in Configuration
- Lock/cache/prot/qos/region/user are not carried. The integrating wrapper ties them off.

## Operation
State machine ST_IDLE → ST_ADDR → ST_DATA → ST_IDLE:
- **ST_IDLE:**
  - Grant a requester only when some s_awvalid is high and out_cnt < MAX_OUTSTANDING.
  - Selection is round-robin: the first requester with s_awvalid set, searching upward from rr_ptr with wrap.
  - On grant, register gnt, set rr_ptr = gnt+1 (mod NUM_PORTS), and go to ST_ADDR.
- **ST_ADDR:**
  - m_aw* = s_aw*[gnt], with m_awid = {gnt, s_awid[gnt]}.
  - s_awready[gnt] = m_awready; all other s_awready are 0.
  - On m_awvalid&&m_awready, go to ST_DATA.
- **ST_DATA:**
  - m_w* = s_w*[gnt]; s_wready[gnt] = m_wready; all other s_wready are 0.
  - On a beat with m_wvalid&&m_wready&&m_wlast, go to ST_IDLE.
- **W ordering:** W beats are taken only from the granted requester. Early W (before AW) stalls until that requester's ST_DATA phase. W order therefore always matches AW order.
- **B path** (combinational, independent of state):
  - idx = m_bid[MIDW-1 -: PW].
  - s_bvalid[idx] = m_bvalid; m_bready = s_bready[idx].
  - s_bid[idx] = m_bid[IDWIDTH-1:0]; s_bresp[idx] = m_bresp.
  - If idx >= NUM_PORTS: m_bready = 1 and the response is dropped.
- **out_cnt** (width $clog2(MAX_OUTSTANDING+1)):
  - +1 on an AW handshake, −1 on a B handshake.
  - Unchanged when both happen in the same cycle.
  - Never wraps, because AW is blocked at MAX_OUTSTANDING.
- A requester must hold s_awvalid once asserted (AXI rule). The arbiter does not re-arbitrate in ST_ADDR.

## Timing
- **Reset** (synchronous, takes effect at the clk edge):
  - state = ST_IDLE, rr_ptr = 0, gnt = 0, out_cnt = 0, len_err = 0.
  - Consequently m_awvalid = 0, m_wvalid = 0, all s_awready = 0, all s_wready = 0.
  - m_bready and s_bvalid follow the combinational B path.
- **Reset mid-burst:** in-flight bursts are abandoned. Upstream and downstream must be reset together.
- **AW latency:** s_awvalid rising in ST_IDLE gives m_awvalid on the next cycle (1 arbitration cycle). AW and W are combinational pass-through once granted.
- **Back-to-back bursts:** minimum one idle cycle between a WLAST beat and the next m_awvalid. A single-beat burst occupies ≥3 cycles.
- **B path:** zero latency, no registers.

## Configuration
Macro `AXI4_WR_ARB_LEN_CHECK_EN`.

Defined:
- A beat counter loads 0 on AW handshake and increments on each W handshake in ST_DATA.
- len_err sets and stays set until reset if either:
  - wlast=1 arrives with count != awlen, or
  - count == awlen with wlast=0.
- The burst is forwarded unchanged; the check is detection only.

Undefined:
- No counter is built and len_err is tied to 0.

## Test plan
- **Single requester:** port0 AW len=3, id=5 → m_awid={0,5}; 4 W beats pass through; m_bid={0,5} returns → s_bvalid[0]=1, s_bid[0]=5, out_cnt 1→0.
- **Round-robin:** ports 0 and 1 both hold awvalid continuously, len=0 → grants alternate 0,1,0,1; no W beat from the ungranted port is accepted.
- **Outstanding limit:** MAX_OUTSTANDING=2, m_bvalid held 0, three bursts queued → third m_awvalid stays 0 until one B handshake, then issues. A simultaneous AW and B handshake leaves out_cnt unchanged.
- **Early W:** port1 drives wvalid 5 cycles before awvalid → s_wready[1]=0 until ST_DATA; data is delivered intact and in order.
- **Length check (macro defined):** awlen=3 with wlast on beat 2 → len_err=1 and it stays 1 until reset. Repeating the same stimulus with the macro undefined → len_err=0.
- **Reset mid-burst:** assert reset during ST_DATA beat 2 → the next cycle shows m_awvalid=0, m_wvalid=0, out_cnt=0, and arbitration restarts at port 0.
